// File: rtl/uart_tx_arbiter_pkg.sv
// Shared state encoding and width helper for the uart transmit arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2,
    ST_WAIT = 2'd3
  } arb_state_t;

  // Like $clog2, but never returns less than 1 so every counter has at least one bit.
  function automatic int clog2_min1(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the pointer, wrapping.
module uart_tx_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   pick_idx,
  output logic            any
);

  int cand;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    cand     = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any && req[cand]) begin
        any        = 1'b1;
        pick[cand] = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmit port between NREQ byte-stream requesters with round-robin,
// packet-locked grants and a strobe/ready holdoff so no byte overruns the uart.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int HOLDOFF = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        txd,
  output logic              txd_strobe,
  input  logic              txd_ready,
  output logic              timeout
);

  localparam int IW = clog2_min1(NREQ);
  localparam int HW = clog2_min1(HOLDOFF + 1);
  localparam int CW = clog2_min1(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NREQ - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLDOFF);
  localparam logic [CW-1:0] IDLE_LIMIT = CW'(TIMEOUT);

  arb_state_t      state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   next_ptr;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick;
  logic            pick_any;
  logic            pkt_end;
  logic [HW-1:0]   hold_cnt;
  logic [CW-1:0]   idle_cnt;

  uart_tx_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req      (req_valid),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // Rotation always restarts just past the requester that last held the port.
  assign next_ptr = (owner == LAST_IDX) ? '0 : owner + IW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      owner      <= '0;
      pkt_end    <= 1'b0;
      hold_cnt   <= '0;
      idle_cnt   <= '0;
      grant      <= '0;
      req_ack    <= '0;
      txd        <= '0;
      txd_strobe <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      txd_strobe <= 1'b0;
      req_ack    <= '0;
      timeout    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (txd_ready && pick_any) begin
            grant   <= pick;
            owner   <= pick_idx;
            pkt_end <= 1'b0;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          txd        <= req_data[8*owner +: 8];
          txd_strobe <= 1'b1;
          req_ack    <= grant;
          hold_cnt   <= HOLD_LOAD;
          idle_cnt   <= '0;
          if (req_last[owner]) begin
            ptr     <= next_ptr;
            pkt_end <= 1'b1;
          end
          state <= ST_HOLD;
        end
        // The uart only drops ready a couple of cycles after our strobe, so ready is ignored here.
        ST_HOLD: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);
          if (hold_cnt <= HW'(1)) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (pkt_end) begin
            if (txd_ready) begin
              grant   <= '0;
              pkt_end <= 1'b0;
              state   <= ST_IDLE;
            end
          end else if (req_valid[owner]) begin
            idle_cnt <= '0;
            if (txd_ready) state <= ST_SEND;
          end else if ((TIMEOUT != 0) && (idle_cnt == IDLE_LIMIT - CW'(1))) begin
            timeout  <= 1'b1;
            ptr      <= next_ptr;
            grant    <= '0;
            idle_cnt <= '0;
            state    <= ST_IDLE;
          end else if (idle_cnt != IDLE_LIMIT) begin
            idle_cnt <= idle_cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: hand sequences, an arbitration table and
// randomized packet streams compared against a packet-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int HOLDOFF = 3;
  localparam int TIMEOUT = 16;
  localparam int DIVISOR = 2;
  localparam int SPACING = HOLDOFF + 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   grant;
  logic [7:0]        txd;
  logic              txd_strobe;
  logic              txd_ready;
  logic              timeout;
  logic              force_ready = 1'b0;
  int                uart_cnt = 0;
  int                cycle = 0;
  int                vectors = 0;
  int                miscompares = 0;

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] exp_grant;
  } arb_vec_t;
  arb_vec_t table_v[10];

  logic [8:0] mem[NREQ][64];
  int         head[NREQ];
  int         tail[NREQ];
  int         gap[NREQ];
  logic [7:0] exp_byte[256];
  int         exp_owner[256];
  bit         exp_last[256];
  int         exp_n;

  uart_tx_arbiter #(
    .NREQ    (NREQ),
    .HOLDOFF (HOLDOFF),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ack    (req_ack),
    .grant      (grant),
    .txd        (txd),
    .txd_strobe (txd_strobe),
    .txd_ready  (txd_ready),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Uart model: ready drops two cycles after a strobe and stays low for DIVISOR*10 cycles.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (txd_strobe) uart_cnt <= DIVISOR * 10 + 1;
    else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
  end
  assign txd_ready = force_ready || (uart_cnt == 0) || (uart_cnt > DIVISOR * 10);

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_strobe(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!txd_strobe && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, " strobe seen"}, 32'(txd_strobe), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (grant != '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, " grant released"}, 32'(grant), 32'd0);
  endtask

  task automatic clear_load();
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
      gap[i]  = 0;
    end
  endtask

  task automatic add_byte(input int r, input logic [7:0] b, input bit last);
    mem[r][tail[r]] = {last, b};
    tail[r]++;
  endtask

  // Packet-level reference: whole packets leave in strict rotation starting at requester 0.
  task automatic build_expected();
    int  h[NREQ];
    int  ptr;
    int  sel;
    bit  more;
    bit  last;
    ptr   = 0;
    exp_n = 0;
    more  = 1'b1;
    for (int i = 0; i < NREQ; i++) h[i] = head[i];
    while (more) begin
      sel = -1;
      for (int k = 0; k < NREQ; k++)
        if (sel < 0 && h[(ptr + k) % NREQ] < tail[(ptr + k) % NREQ]) sel = (ptr + k) % NREQ;
      if (sel < 0) begin
        more = 1'b0;
      end else begin
        last = 1'b0;
        while (!last && h[sel] < tail[sel]) begin
          exp_byte[exp_n]  = mem[sel][h[sel]][7:0];
          exp_owner[exp_n] = sel;
          last             = mem[sel][h[sel]][8];
          exp_last[exp_n]  = last;
          exp_n++;
          h[sel]++;
        end
        ptr = (sel + 1) % NREQ;
      end
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      if (head[i] < tail[i] && gap[i] == 0) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = mem[i][head[i]][7:0];
        req_last[i]         = mem[i][head[i]][8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  function automatic bit all_done();
    for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_stream(input string name, input bit exact, input int gap_max);
    int n;
    int exp_i;
    int strobes;
    int timeouts;
    int last_cyc;
    bit prev_last;
    build_expected();
    exp_i     = 0;
    strobes   = 0;
    timeouts  = 0;
    last_cyc  = -1;
    prev_last = 1'b1;
    n         = 0;
    drive_reqs();
    while (n < 6000 && !(exp_i == exp_n && all_done() && grant == '0)) begin
      @(negedge clk);
      n++;
      if (txd_strobe) begin
        strobes++;
        if (exp_i < exp_n) begin
          check({name, " txd"}, 32'(txd), 32'(exp_byte[exp_i]));
          check({name, " grant"}, 32'(grant), 32'(1 << exp_owner[exp_i]));
          check({name, " ack"}, 32'(req_ack), 32'(1 << exp_owner[exp_i]));
          if (last_cyc >= 0) begin
            if (exact && !prev_last) check({name, " spacing"}, 32'(cycle - last_cyc), 32'(SPACING));
            else check({name, " min spacing"}, 32'(cycle - last_cyc >= SPACING), 32'd1);
          end
          prev_last = exp_last[exp_i];
          exp_i++;
        end
        last_cyc = cycle;
      end
      if (timeout) timeouts++;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ack[i] && head[i] < tail[i]) begin
          if (!mem[i][head[i]][8]) gap[i] = $urandom_range(gap_max, 0);
          head[i]++;
        end else if (gap[i] > 0) begin
          gap[i]--;
        end
      end
      drive_reqs();
    end
    check({name, " strobe count"}, 32'(strobes), 32'(exp_n));
    check({name, " no timeout"}, 32'(timeouts), 32'd0);
    req_valid = '0;
    req_last  = '0;
  endtask

  initial begin
    logic [NREQ-1:0] seq[3];
    int              start;
    int              n;
    int              idx;
    int              npk;
    int              len;

    table_v[0] = '{4'b0001, 4'b0001};
    table_v[1] = '{4'b0001, 4'b0001};
    table_v[2] = '{4'b1111, 4'b0010};
    table_v[3] = '{4'b1011, 4'b1000};
    table_v[4] = '{4'b0110, 4'b0010};
    table_v[5] = '{4'b0101, 4'b0100};
    table_v[6] = '{4'b0011, 4'b0001};
    table_v[7] = '{4'b1100, 4'b0100};
    table_v[8] = '{4'b1000, 4'b1000};
    table_v[9] = '{4'b1110, 4'b0010};

    // Reset values
    do_reset();
    check("reset grant", 32'(grant), 32'd0);
    check("reset txd", 32'(txd), 32'd0);
    check("reset strobe", 32'(txd_strobe), 32'd0);
    check("reset ack", 32'(req_ack), 32'd0);
    check("reset timeout", 32'(timeout), 32'd0);

    // Single two-byte packet, then the pointer must favour requester 1
    req_data[7:0] = 8'h41;
    req_last      = '0;
    req_valid     = 4'b0001;
    wait_strobe("single b0");
    check("single txd0", 32'(txd), 32'h41);
    check("single grant0", 32'(grant), 32'b0001);
    check("single ack0", 32'(req_ack), 32'b0001);
    req_data[7:0] = 8'h42;
    req_last[0]   = 1'b1;
    wait_strobe("single b1");
    check("single txd1", 32'(txd), 32'h42);
    check("single ack1", 32'(req_ack), 32'b0001);
    req_valid = '0;
    req_last  = '0;
    wait_idle("single");
    req_data  = {8'h00, 8'h00, 8'h21, 8'h20};
    req_last  = 4'b0011;
    req_valid = 4'b0011;
    wait_strobe("pointer");
    check("pointer grant", 32'(grant), 32'b0010);
    check("pointer txd", 32'(txd), 32'h21);
    req_valid = '0;
    req_last  = '0;
    wait_idle("pointer");

    // Arbitration table: single-byte packets, pointer carried row to row
    do_reset();
    for (int r = 0; r < 10; r++) begin
      wait_idle("table pre");
      for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = {4'(i), 4'(r)};
      req_last  = '1;
      req_valid = table_v[r].valid;
      wait_strobe("table");
      idx = 0;
      for (int i = 0; i < NREQ; i++) if (table_v[r].exp_grant[i]) idx = i;
      check("table grant", 32'(grant), 32'(table_v[r].exp_grant));
      check("table txd", 32'(txd), 32'({4'(idx), 4'(r)}));
      req_valid = '0;
    end
    req_last = '0;
    wait_idle("table");

    // Fairness: req1 streams single-byte packets, req3 must get in after one of them
    do_reset();
    req_data  = {8'h33, 8'h00, 8'h11, 8'h00};
    req_last  = 4'b1010;
    req_valid = 4'b1010;
    for (int s = 0; s < 3; s++) begin
      wait_strobe("fair");
      seq[s] = grant;
      if (req_ack[3]) req_valid[3] = 1'b0;
      if (req_ack[1]) req_data[15:8] = req_data[15:8] + 8'd1;
    end
    req_valid = '0;
    req_last  = '0;
    check("fair first", 32'(seq[0]), 32'b0010);
    check("fair second", 32'(seq[1]), 32'b1000);
    check("fair third", 32'(seq[2]), 32'b0010);
    wait_idle("fair");

    // Stall: req2 stops mid-packet, lock released after TIMEOUT wait cycles
    do_reset();
    req_data[23:16] = 8'h10;
    req_data[31:24] = 8'h33;
    req_last        = 4'b1000;
    req_valid       = 4'b1100;
    wait_strobe("stall");
    check("stall grant", 32'(grant), 32'b0100);
    check("stall txd", 32'(txd), 32'h10);
    req_valid[2] = 1'b0;
    start        = cycle;
    n            = 0;
    while (!timeout && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall timeout pulse", 32'(timeout), 32'd1);
    check("stall timeout latency", 32'(cycle - start), 32'(HOLDOFF + TIMEOUT));
    check("stall grant dropped", 32'(grant), 32'd0);
    wait_strobe("stall next");
    check("stall next grant", 32'(grant), 32'b1000);
    check("stall next txd", 32'(txd), 32'h33);
    req_valid = '0;
    req_last  = '0;
    wait_idle("stall");

    // Reset mid-packet: outputs clear at once, requester 0 wins afterwards
    do_reset();
    req_data[15:8] = 8'h77;
    req_last       = '0;
    req_valid      = 4'b0010;
    wait_strobe("midreset");
    reset = 1'b1;
    #1;
    check("midreset grant", 32'(grant), 32'd0);
    check("midreset strobe", 32'(txd_strobe), 32'd0);
    check("midreset ack", 32'(req_ack), 32'd0);
    check("midreset txd", 32'(txd), 32'd0);
    check("midreset timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    reset         = 1'b0;
    req_data[7:0] = 8'h55;
    req_last      = 4'b0001;
    req_valid     = 4'b0011;
    wait_strobe("after reset");
    check("after reset grant", 32'(grant), 32'b0001);
    check("after reset txd", 32'(txd), 32'h55);
    req_valid = '0;
    req_last  = '0;
    wait_idle("after reset");

    // Contention: two 3-byte packets must not interleave
    do_reset();
    clear_load();
    for (int b = 0; b < 3; b++) add_byte(0, 8'hA0 + 8'(b), b == 2);
    for (int b = 0; b < 3; b++) add_byte(2, 8'hC0 + 8'(b), b == 2);
    run_stream("contention", 1'b0, 2);

    // Ready held high: strobes inside a packet are exactly HOLDOFF+2 apart
    do_reset();
    force_ready = 1'b1;
    clear_load();
    for (int b = 0; b < 4; b++) add_byte(0, 8'h60 + 8'(b), b == 3);
    for (int b = 0; b < 2; b++) add_byte(1, 8'h70 + 8'(b), b == 1);
    run_stream("handshake", 1'b1, 0);
    force_ready = 1'b0;

    // Randomized packet loads with mid-packet valid gaps
    for (int rnd = 0; rnd < 4; rnd++) begin
      do_reset();
      clear_load();
      for (int r = 0; r < NREQ; r++) begin
        npk = $urandom_range(3, 0);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(4, 1);
          for (int b = 0; b < len; b++) add_byte(r, 8'($urandom), b == len - 1);
        end
      end
      run_stream("random", 1'b0, 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
